// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback units, with bounded lock.
// Latency: 1 cycle from a granted request to write/writeReg/writeData. Backpressure: req_ready only; the output stage always accepts.
// Optional macro REGFILE_ARB_ZERO_PROTECT_EN: transfers to register 0 are accepted but never written.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [5*NUM_REQ-1:0]    req_reg,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [4:0]              writeReg,
  output logic [31:0]             writeData,
  output logic                    write,
  output logic [2:0]              grant_id,
  output logic [31:0]             busy_mask
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          r_state;
  logic [2:0]      r_last;
  logic [2:0]      r_owner;
  logic [CW-1:0]   r_lock_cnt;

  logic            w_win_vld;
  logic [2:0]      w_win;
  logic [2:0]      w_sel;
  logic            w_xfer;
  logic            w_sel_lock;
  logic [4:0]      w_sel_reg;
  logic [31:0]     w_sel_data;
  logic            w_cnt_last;

  // First valid requester after last_grant, wrapping.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_win_vld && req_valid[i] && (((int'(r_last) + k) % NUM_REQ) == i)) begin
          w_win_vld = 1'b1;
          w_win     = 3'(i);
        end
      end
    end
  end

  assign w_sel = (r_state == ST_ARB) ? w_win : r_owner;

  always_comb begin
    req_ready = '0;
    if (resetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_state == ST_ARB)
          req_ready[i] = w_win_vld && (w_win == 3'(i));
        else
          req_ready[i] = req_valid[i] && (r_owner == 3'(i));
      end
    end
  end

  assign w_xfer = |(req_valid & req_ready);

  always_comb begin
    w_sel_lock = 1'b0;
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_lock = req_lock[i];
        w_sel_reg  = req_reg[5*i +: 5];
        w_sel_data = req_data[32*i +: 32];
      end
    end
  end

  assign w_cnt_last = (int'(r_lock_cnt) + 1) >= MAX_LOCK;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      write      <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      grant_id   <= '0;
      r_state    <= ST_ARB;
      r_last     <= 3'(NUM_REQ - 1);
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
`ifdef REGFILE_ARB_ZERO_PROTECT_EN
      write <= w_xfer && (w_sel_reg != 5'd0);
`else
      write <= w_xfer;
`endif
      if (w_xfer) begin
        writeReg  <= w_sel_reg;
        writeData <= w_sel_data;
        grant_id  <= w_sel;
      end
      case (r_state)
        ST_ARB: begin
          if (w_xfer) begin
            r_last <= w_win;
            if (w_sel_lock && (MAX_LOCK > 1)) begin
              r_state    <= ST_LOCKED;
              r_owner    <= w_win;
              r_lock_cnt <= CW'(1);
            end
          end
        end
        default: begin
          // Owner keeps lowest priority once it gives up the port.
          r_last <= r_owner;
          if (w_xfer) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            if (!w_sel_lock || w_cnt_last) begin
              r_state    <= ST_ARB;
              r_lock_cnt <= '0;
            end
          end else begin
            r_state    <= ST_ARB;
            r_lock_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy_mask = '0;
    if (write)
      busy_mask[writeReg] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter against a transaction-level reference model.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int ML = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic [N-1:0]     req_valid, req_lock, req_ready;
  logic [5*N-1:0]   req_reg;
  logic [32*N-1:0]  req_data;
  logic [4:0]       writeReg;
  logic [31:0]      writeData, busy_mask;
  logic             write;
  logic [2:0]       grant_id;

  int total = 0;
  int bad   = 0;

  // Reference model: arbitration history and expected output stage
  int          m_last, m_owner, m_run;
  bit          m_locked;
  bit          m_write;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_gid;
  logic [N-1:0] exp_rdy;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_lock(req_lock),
    .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .writeReg(writeReg), .writeData(writeData), .write(write),
    .grant_id(grant_id), .busy_mask(busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int idx;
    r = '0;
    if (!resetn) return r;
    if (m_locked) begin
      r[m_owner] = req_valid[m_owner];
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (r == '0 && req_valid[idx]) r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_clk(input logic [N-1:0] rdy);
    int id;
    id = -1;
    if (!resetn) begin
      m_write = 0; m_reg = '0; m_data = '0; m_gid = 0;
      m_last = N - 1; m_locked = 0; m_run = 0; m_owner = 0;
      return;
    end
    for (int i = 0; i < N; i++) if (rdy[i] && req_valid[i]) id = i;
    m_write = (id >= 0);
    if (id >= 0) begin
      m_reg  = req_reg[5*id +: 5];
      m_data = req_data[32*id +: 32];
      m_gid  = id;
`ifdef REGFILE_ARB_ZERO_PROTECT_EN
      if (m_reg == 5'd0) m_write = 0;
`endif
    end
    if (m_locked) begin
      m_last = m_owner;
      if (id < 0) m_locked = 0;
      else begin
        m_run++;
        if (!req_lock[id] || m_run == ML) m_locked = 0;
      end
    end else if (id >= 0) begin
      m_last = id;
      if (req_lock[id] && ML > 1) begin
        m_locked = 1; m_owner = id; m_run = 1;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs after it.
  task automatic step(input logic rn, input logic [N-1:0] v, input logic [N-1:0] l);
    @(negedge clock);
    resetn = rn; req_valid = v; req_lock = l;
    #1;
    exp_rdy = model_ready();
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clock);
    model_clk(exp_rdy);
    #1;
    chk("write", 32'(write), 32'(m_write));
    chk("writeReg", 32'(writeReg), 32'(m_reg));
    chk("writeData", writeData, m_data);
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy_mask", busy_mask, m_write ? (32'd1 << m_reg) : 32'd0);
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[5*i +: 5]    = r;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    int exp_seq [6];
    logic [N-1:0] prev_v;
    resetn = 1'b0; req_valid = '0; req_lock = '0; req_reg = '0; req_data = '0;
    m_last = N - 1; m_locked = 0; m_run = 0; m_owner = 0;
    m_write = 0; m_reg = '0; m_data = '0; m_gid = 0;

    // Reset with every requester asking
    set_req(0, 5'd5, 32'hA); set_req(1, 5'd6, 32'hB); set_req(2, 5'd7, 32'hC);
    step(1'b0, 3'b111, 3'b000);
    step(1'b0, 3'b111, 3'b000);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_write", 32'(write), 32'd0);

    // Round-robin: grants 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 3'b111, 3'b000);
      chk("rr_gid", 32'(grant_id), 32'(c % 3));
      chk("rr_reg", 32'(writeReg), 32'(5 + c % 3));
      chk("rr_data", writeData, 32'(10 + c % 3));
    end

    // Lock limit: req1 locked competes with req0
    step(1'b1, 3'b001, 3'b000);
    exp_seq = '{1, 1, 1, 1, 0, 1};
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 3'b011, 3'b010);
      chk("lock_gid", 32'(grant_id), 32'(exp_seq[c]));
    end
    step(1'b1, 3'b000, 3'b000);

    // Lock release: req2 two locked transfers, then drops valid while req0 waits
    step(1'b1, 3'b100, 3'b100);
    chk("rel_gid0", 32'(grant_id), 32'd2);
    step(1'b1, 3'b101, 3'b100);
    chk("rel_gid1", 32'(grant_id), 32'd2);
    step(1'b1, 3'b001, 3'b000);
    chk("rel_idle", 32'(write), 32'd0);
    step(1'b1, 3'b001, 3'b000);
    chk("rel_req0", 32'(grant_id), 32'd0);
    chk("rel_req0_w", 32'(write), 32'd1);

    // Reset while a write is on the output stage
    set_req(0, 5'd9, 32'h55);
    step(1'b1, 3'b001, 3'b000);
    chk("mid_w", 32'(write), 32'd1);
    chk("mid_reg", 32'(writeReg), 32'd9);
    step(1'b0, 3'b001, 3'b000);
    chk("mid_rst_w", 32'(write), 32'd0);
    chk("mid_rst_reg", 32'(writeReg), 32'd0);

    // Write to register 0 (last_grant=2 after reset, so req0 wins)
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 3'b001, 3'b000);
    chk("zero_ready", 32'(exp_rdy), 32'b001);
`ifdef REGFILE_ARB_ZERO_PROTECT_EN
    chk("zero_w", 32'(write), 32'd0);
    chk("zero_busy", busy_mask, 32'd0);
`else
    chk("zero_w", 32'(write), 32'd1);
    chk("zero_reg", 32'(writeReg), 32'd0);
    chk("zero_busy", busy_mask, 32'd1);
`endif

    // Random traffic; pending requests keep their payload stable
    prev_v = '0;
    exp_rdy = '0;
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] v, l;
      for (int i = 0; i < N; i++)
        if (!(prev_v[i] && !exp_rdy[i]))
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
      v = N'($urandom);
      l = N'($urandom);
      step(($urandom_range(0, 31) != 0), v, l);
      prev_v = resetn ? v : '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
